// File: rtl/la_rrarb.sv
// la_rrarb: round-robin arbiter that shares one resource (mux select, OR-merge
// enable, shared bus) between N requesters.
//
// The grant is registered and one-hot (or zero), so it is glitch-free. There is
// no combinational path from req to gnt. With HOLD=1, the current holder keeps
// the grant while its request stays high. MAXCYC, when non-zero, caps how many
// consecutive cycles one holder may keep the grant.
//
// Parameters:
//   N       number of requesters (N >= 1)
//   HOLD    1: holder keeps grant while requesting, 0: rearbitrate every cycle
//   MAXCYC  max consecutive grant cycles per holder when HOLD=1, 0 = unlimited
//   PROP    implementation property string for downstream cells
//
// Ports:
//   clk     in   1    clock, rising edge
//   nreset  in   1    asynchronous active-low reset
//   en      in   1    arbitration enable
//   req     in   N    request vector, bit i = requester i
//   gnt     out  N    registered one-hot (or zero) grant vector
//   gnt_id  out  IW   binary index of the granted requester, 0 when idle
//   busy    out  1    registered |gnt
module la_rrarb #(
  parameter int    N      = 4,
  parameter int    HOLD   = 1,
  parameter int    MAXCYC = 0,
  parameter string PROP   = "DEFAULT",
  localparam int   IW     = (N > 1) ? $clog2(N) : 1,
  localparam int   CW     = (MAXCYC > 0) ? $clog2(MAXCYC + 1) : 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [CW-1:0]  cnt;

  logic           win_found;
  logic [IW-1:0]  win_id;
  logic [N-1:0]   win_gnt;
  logic [IW-1:0]  ptr_next;
  logic           hold_ok;

  // Rotating priority search. The search starts at ptr and wraps modulo N.
  // The first requester found wins.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    win_gnt   = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!win_found && req[idx]) begin
        win_found    = 1'b1;
        win_id       = idx[IW-1:0];
        win_gnt[idx] = 1'b1;
      end
    end
  end

  // After a grant, the requester just after the winner gets top priority.
  always_comb begin
    if (int'(win_id) == N - 1) ptr_next = '0;
    else                       ptr_next = win_id + IW'(1);
  end

  // The holder may keep the grant only while it still requests and has not
  // used up its burst. cnt counts the extra cycles after the first grant
  // cycle, so the cap is reached when cnt hits MAXCYC-1.
  always_comb begin
    hold_ok = (HOLD != 0) && (state == GRANT) && req[gnt_id] &&
              ((MAXCYC == 0) || (int'(cnt) < MAXCYC - 1));
  end

  // Arbitration FSM. All outputs are registered here. Dropping en freezes ptr
  // and cnt. A stale cnt is harmless because every fresh grant clears it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
      ptr    <= '0;
      cnt    <= '0;
    end else if (!en) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
    end else if (hold_ok) begin
      if (cnt != {CW{1'b1}}) cnt <= cnt + CW'(1);
    end else if (win_found) begin
      state  <= GRANT;
      gnt    <= win_gnt;
      gnt_id <= win_id;
      busy   <= 1'b1;
      ptr    <= ptr_next;
      cnt    <= '0;
    end else begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
    end
  end

endmodule
